// File: rtl/mopa_unit.sv
// mopa_unit: 4x4 int8 outer-product accumulate unit.
// Each accepted MOPA issue adds a[i]*b[j] into the 32-bit accumulator
// acc[4*i+j], one element per cycle. That gives sixteen cycles of work,
// and busy_o is high for all of them. A single done_o pulse follows.
module mopa_unit (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  alu_ctrl_i,
    input  logic        issue_valid_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic        clr_i,
    input  logic [3:0]  rd_idx_i,
    output logic [31:0] rd_data_o,
    output logic        busy_o,
    output logic        done_o
);

    // MOPA code in the shared ALU control encoding.
    localparam logic [3:0] ALU_MOPA = 4'hD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [3:0]         k;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [31:0]        acc [16];

    logic               accept;
    logic signed [7:0]  a_el;
    logic signed [7:0]  b_el;
    logic signed [31:0] a_ext;
    logic signed [31:0] b_ext;
    logic [31:0]        prod;

    assign accept = (state == IDLE) && issue_valid_i && (alu_ctrl_i == ALU_MOPA);

    // Select this step's operands, sign-extend them, and form the wrapped 32-bit product.
    always_comb begin
        a_el  = a_q[{k[3:2], 3'b000} +: 8];
        b_el  = b_q[{k[1:0], 3'b000} +: 8];
        a_ext = 32'(a_el);
        b_ext = 32'(b_el);
        prod  = a_ext * b_ext;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // flop samples pre-edge values no matter how the blocks are ordered.
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and status outputs.
    always_comb begin
        // NOTE: give every output a default first. A path that does not
        // assign a signal would otherwise infer a latch.
        state_next = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        unique case (state)
            IDLE: if (accept) state_next = CALC;
            CALC: begin
                busy_o = 1'b1;
                if (k == 4'd15) state_next = DONE;
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, step counter, and accumulator tile update.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            k   <= 4'd0;
            a_q <= 32'd0;
            b_q <= 32'd0;
            // NOTE: the accumulator array is reset explicitly. A reset must
            // leave the tile reading all zeros, so it cannot be left as
            // uninitialised storage.
            for (int n = 0; n < 16; n++) acc[n] <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clr_i) begin
                        for (int n = 0; n < 16; n++) acc[n] <= 32'd0;
                    end
                    if (accept) begin
                        a_q <= src1_i;
                        b_q <= src2_i;
                        k   <= 4'd0;
                    end
                end
                CALC: begin
                    acc[k] <= acc[k] + prod;
                    k      <= k + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign rd_data_o = acc[rd_idx_i];

endmodule

// File: tb/tb_mopa_unit.sv
// tb_mopa_unit: directed and randomized checks of mopa_unit.
// The reference model is an array of sixteen accumulators. Each accepted
// issue adds the full outer product to it.
module tb_mopa_unit;

    localparam logic [3:0] ALU_MOPA = 4'hD;
    localparam logic [3:0] ALU_ADD  = 4'h2;

    logic        clk;
    logic        rstn;
    logic [3:0]  alu_ctrl_i;
    logic        issue_valid_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        clr_i;
    logic [3:0]  rd_idx_i;
    logic [31:0] rd_data_o;
    logic        busy_o;
    logic        done_o;

    int          checks;
    int          failures;
    logic [31:0] model [16];

    mopa_unit dut (
        .clk           (clk),
        .rstn          (rstn),
        .alu_ctrl_i    (alu_ctrl_i),
        .issue_valid_i (issue_valid_i),
        .src1_i        (src1_i),
        .src2_i        (src2_i),
        .clr_i         (clr_i),
        .rd_idx_i      (rd_idx_i),
        .rd_data_o     (rd_data_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop so the bench cannot hang.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then step off it to sample.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every accumulator against the model. Call only while the unit is quiet.
    task automatic read_all(input string tag);
        for (int n = 0; n < 16; n++) begin
            rd_idx_i = 4'(n);
            #1;
            check($sformatf("%s_acc%0d", tag, n), rd_data_o, model[n]);
        end
    endtask

    // Outer-product accumulate applied to the model: acc[4i+j] += a[i]*b[j].
    task automatic model_mopa(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                int ai;
                int bj;
                ai = int'($signed(a[8*i +: 8]));
                bj = int'($signed(b[8*j +: 8]));
                model[4*i + j] = model[4*i + j] + 32'(ai * bj);
            end
        end
    endtask

    task automatic model_clear();
        for (int n = 0; n < 16; n++) model[n] = 32'd0;
    endtask

    // Run one full MOPA operation. The caller may also request a clear on the
    // accept cycle. With disturb set, the bench issues again and asserts
    // clr_i partway through CALC and during DONE; the unit must ignore both.
    task automatic mopa_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input bit clr, input bit disturb);
        alu_ctrl_i    = ALU_MOPA;
        issue_valid_i = 1'b1;
        src1_i        = a;
        src2_i        = b;
        clr_i         = clr;
        tick();                       // accept edge T
        issue_valid_i = 1'b0;
        clr_i         = 1'b0;
        src1_i        = $urandom;
        src2_i        = $urandom;
        if (clr) model_clear();
        model_mopa(a, b);
        for (int c = 0; c < 16; c++) begin
            check($sformatf("%s_busy_c%0d", tag, c), 32'(busy_o), 32'd1);
            check($sformatf("%s_done_c%0d", tag, c), 32'(done_o), 32'd0);
            if (disturb && c == 5) begin
                issue_valid_i = 1'b1;
                clr_i         = 1'b1;
            end else begin
                issue_valid_i = 1'b0;
                clr_i         = 1'b0;
            end
            tick();
        end
        // Now past edge T+16, in DONE.
        check({tag, "_done_pulse"}, 32'(done_o), 32'd1);
        check({tag, "_busy_done"},  32'(busy_o), 32'd0);
        if (disturb) begin
            issue_valid_i = 1'b1;
            clr_i         = 1'b1;
        end
        tick();
        issue_valid_i = 1'b0;
        clr_i         = 1'b0;
        check({tag, "_done_low"}, 32'(done_o), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy_o), 32'd0);
        tick();
        check({tag, "_idle_stays"}, 32'(busy_o), 32'd0);
        read_all(tag);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rstn          = 1'b0;
        alu_ctrl_i    = ALU_ADD;
        issue_valid_i = 1'b0;
        src1_i        = 32'd0;
        src2_i        = 32'd0;
        clr_i         = 1'b0;
        rd_idx_i      = 4'd0;
        model_clear();
        tick();
        tick();
        rstn = 1'b1;

        // Reset state
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        read_all("rst");

        // Basic run
        mopa_run("basic", 32'h04030201, 32'h01010101, 1'b0, 1'b0);

        // Clear in IDLE
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        model_clear();
        read_all("clr_idle");

        // Signed products, then accumulation onto the previous result
        mopa_run("signed1", 32'h000000FF, 32'h00000080, 1'b0, 1'b0);
        mopa_run("signed2", 32'h000000FF, 32'h00000080, 1'b0, 1'b0);

        // Issue and clear in CALC and DONE are ignored
        mopa_run("busyrej", 32'h7F80FF01, 32'h80017FFF, 1'b0, 1'b1);

        // Clear and accept in the same cycle: clear first, then accumulate onto zero
        mopa_run("clr_issue", 32'h05FB0A81, 32'hFE0364C0, 1'b1, 1'b0);

        // Non-MOPA code is ignored
        alu_ctrl_i    = ALU_ADD;
        issue_valid_i = 1'b1;
        src1_i        = 32'h11111111;
        src2_i        = 32'h22222222;
        tick();
        check("nonmopa_busy1", 32'(busy_o), 32'd0);
        tick();
        issue_valid_i = 1'b0;
        check("nonmopa_busy2", 32'(busy_o), 32'd0);
        check("nonmopa_done", 32'(done_o), 32'd0);
        read_all("nonmopa");

        // Randomized operations
        for (int r = 0; r < 6; r++) begin
            mopa_run($sformatf("rnd%0d", r), $urandom, $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset mid-operation
        alu_ctrl_i    = ALU_MOPA;
        issue_valid_i = 1'b1;
        src1_i        = 32'h7F7F7F7F;
        src2_i        = 32'h7F7F7F7F;
        tick();                       // accept edge T
        issue_valid_i = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        check("midrst_busy_pre", 32'(busy_o), 32'd1);
        rstn = 1'b0;
        tick();                       // edge T+8 under reset
        rstn = 1'b1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        model_clear();
        for (int c = 0; c < 12; c++) begin
            tick();
            check($sformatf("midrst_nodone%0d", c), 32'(done_o), 32'd0);
        end
        read_all("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mopa_unit.md
MOPA_UNIT -- requirements
Module: mopa_unit

Interface
REQ-001 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL provide port rstn, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL provide port alu_ctrl_i, input, 4 bits: ALU control code from the ALU-control decoder.
REQ-004 SHALL provide port issue_valid_i, input, 1 bit: an instruction is presented this cycle.
REQ-005 SHALL provide port src1_i, input, 32 bits: vector A; element a[i] = src1_i[8i+7:8i], signed int8, i=0..3.
REQ-006 SHALL provide port src2_i, input, 32 bits: vector B; element b[j] = src2_i[8j+7:8j], signed int8, j=0..3.
REQ-007 SHALL provide port clr_i, input, 1 bit: request to zero all accumulators.
REQ-008 SHALL provide port rd_idx_i, input, 4 bits: accumulator read index k = 4*i + j.
REQ-009 SHALL provide port rd_data_o, output, 32 bits: contents of acc[rd_idx_i].
REQ-010 SHALL provide port busy_o, output, 1 bit: unit computing; pipeline stall request.
REQ-011 SHALL provide port done_o, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 SHALL hold sixteen 32-bit accumulators acc[0..15] forming a 4x4 tile.
REQ-013 SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-014 SHALL accept an issue only in IDLE, and only when issue_valid_i=1 and alu_ctrl_i equals the MOPA code from the shared ALU define header.
REQ-015 On accept, SHALL latch src1_i and src2_i, clear step counter k to 0, and enter CALC.
REQ-016 SHALL ignore issue_valid_i when alu_ctrl_i is any non-MOPA code, and SHALL ignore any issue while in CALC or DONE; such issues are neither queued nor change state.
REQ-017 In CALC, each cycle SHALL perform acc[k] <= acc[k] + sext32(a[k[3:2]]) * sext32(b[k[1:0]]) using the latched operands, then increment k.
REQ-018 Accumulation SHALL wrap modulo 2^32 with no saturation and no overflow flag.
REQ-019 After the step with k=15, SHALL enter DONE; in DONE, SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-020 Latency: for an accept at edge T, the MAC updates SHALL occur at edges T+1..T+16, and done_o SHALL be high during the cycle after edge T+16.
REQ-021 busy_o SHALL be high exactly while in CALC; done_o SHALL be high only in DONE.
REQ-022 clr_i SHALL zero all accumulators at the next edge only when in IDLE, and SHALL be ignored in CALC and DONE.
REQ-023 With clr_i and an accepted issue in the same IDLE cycle, SHALL clear first; the first MAC step then adds onto zero.
REQ-024 rd_data_o SHALL be combinational from acc[rd_idx_i], valid in every state; during CALC it shows partial sums.

Reset
REQ-025 rstn=0 at an edge SHALL force: state IDLE, k=0, latched operands=0, acc[0..15]=0, busy_o=0, done_o=0.
REQ-026 Reset SHALL take priority over issue and clear, and SHALL abort an in-progress CALC with no done_o pulse.

Verification
REQ-027 Basic run: after reset, issue MOPA with src1=0x04030201 and src2=0x01010101 -> busy_o high for 16 cycles, then one done_o pulse; acc[0..3]=1, acc[4..7]=2, acc[8..11]=3, acc[12..15]=4.
REQ-028 Signed and accumulate: src1=0x000000FF and src2=0x00000080 -> acc[0]=128 (0x00000080) and all other accumulators 0; a second identical issue -> acc[0]=256.
REQ-029 Busy rejection: issue at T, then a second MOPA issue at T+5 -> exactly one accumulation, a single done_o pulse after edge T+16, and the unit returns to IDLE.
REQ-030 Clear: with nonzero acc, clr_i in IDLE -> all 16 reads return 0; clr_i asserted during CALC -> accumulation is unaffected.
REQ-031 Reset mid-op: rstn=0 at T+8 of a run -> busy_o=0, all acc=0, and no done_o pulse.
REQ-032 Non-MOPA: issue_valid_i=1 with the ADD code -> state remains IDLE, busy_o=0, and acc is unchanged.
